// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch sequencer: PC register, fetch/exec/halt/fault control, fetch timeout
// Optional retired-instruction counter enabled by defining PCF_PERF_CNT_EN.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [31:0] in_pcin,
    input  logic        in_stall,
    input  logic        in_halt,
    input  logic        in_go,
    input  logic        in_imem_ack,
    input  logic [31:0] in_imem_data,
    output logic [31:0] out_pcout,
    output logic        out_imem_req,
    output logic [31:0] out_imem_addr,
    output logic [31:0] out_instr,
    output logic        out_instr_valid,
    output logic        out_halted,
    output logic        out_fault,
    output logic [31:0] out_retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam int unsigned   CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;
    logic          fault_q, fault_d;

    // req_q low while in FETCH marks the first cycle after reset: no request is out,
    // so an ack seen then is stale and gets dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            FETCH: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (in_imem_ack) begin
                    instr_d = in_imem_data;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == TO_LAST) begin
                        req_d   = 1'b0;
                        state_d = FAULT;
                    end
                end
            end
            EXEC: begin
                if (!in_stall) begin
                    if (in_halt) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = in_pcin;
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                if (in_go) begin
                    pc_d    = in_pcin;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
                req_d   = 1'b0;
            end
        endcase
        valid_d  = (state_d == EXEC);
        halted_d = (state_d == HALT);
        fault_d  = (state_d == FAULT);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign out_pcout       = pc_q;
    assign out_imem_req    = req_q;
    assign out_imem_addr   = pc_q;
    assign out_instr       = instr_q;
    assign out_instr_valid = valid_q;
    assign out_halted      = halted_q;
    assign out_fault       = fault_q;

`ifdef PCF_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;

    // An instruction retires when EXEC is left, whether to FETCH or to HALT.
    always_comb begin
        retired_d = retired_q;
        if (state_q == EXEC && !in_stall) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign out_retired = retired_q;
`else
    assign out_retired = 32'd0;
`endif

endmodule
